// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier FSM state encoding,
// NZCV flag bit positions and the multiply iteration count.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned MUL_ITERS = 32;

endpackage

// File: rtl/mul_unit_if.sv
// Multiplier request/response bundle.
// master: issues start + operands, sees busy/done/result/strobes.
// slave : the multiplier side of the same signals.
interface mul_unit_if;
  logic        start;
  logic        accumulate;
  logic        set_flags;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] acc_in;
  logic [3:0]  dest_sel;
  logic [3:0]  flags_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  result_sel;
  logic        we;
  logic [3:0]  flags_out;
  logic        flags_we;

  modport master (
    output start, accumulate, set_flags,
    output op_a, op_b, acc_in,
    output dest_sel, flags_in,
    input  busy, done, result, result_sel,
    input  we, flags_out, flags_we
  );

  modport slave (
    input  start, accumulate, set_flags,
    input  op_a, op_b, acc_in,
    input  dest_sel, flags_in,
    output busy, done, result, result_sel,
    output we, flags_out, flags_we
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add 32x32->32 multiplier (MUL/MLA) with NZCV update.
// Ports: clock, reset (async, active-high), bus (mul_unit_if.slave).
// Build option: MUL_EARLY_TERM_EN stops RUN once the multiplier is zero.
module mul_unit
  import cpu_pkg::*;
(
  input logic       clock,
  input logic       reset,
  mul_unit_if.slave bus
);

  mul_state_e  r_state;
  mul_state_e  w_next;
  logic [31:0] r_ma;
  logic [31:0] r_mb;
  logic [31:0] r_prod;
  logic [4:0]  r_cnt;
  logic [3:0]  r_dest;
  logic        r_sf;
  logic        r_c;
  logic        r_v;
  logic [31:0] r_result;
  logic [3:0]  r_rsel;
  logic [3:0]  r_flags;
  logic [31:0] w_add;
  logic [3:0]  w_flags;
  logic        w_last;

  assign w_add = r_mb[0] ? r_prod + r_ma : r_prod;

`ifdef MUL_EARLY_TERM_EN
  // Remaining multiplier bits all zero: later iterations add nothing.
  assign w_last = (r_mb[31:1] == 31'd0) ||
                  (r_cnt == 5'(MUL_ITERS - 1));
`else
  assign w_last = (r_cnt == 5'(MUL_ITERS - 1));
`endif

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_add[31];
    w_flags[FLAG_Z] = (w_add == 32'd0);
    w_flags[FLAG_C] = r_c;
    w_flags[FLAG_V] = r_v;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.we       = 1'b0;
    bus.flags_we = 1'b0;
    unique case (r_state)
      S_RUN: bus.busy = 1'b1;
      S_DONE: begin
        bus.busy     = 1'b1;
        bus.done     = 1'b1;
        bus.we       = (r_rsel != 4'hF);
        bus.flags_we = r_sf;
      end
      default: ;
    endcase
  end

  assign bus.result     = r_result;
  assign bus.result_sel = r_rsel;
  assign bus.flags_out  = r_flags;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ma     <= '0;
      r_mb     <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_dest   <= '0;
      r_sf     <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_result <= '0;
      r_rsel   <= '0;
      r_flags  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          r_ma   <= bus.op_a;
          r_mb   <= bus.op_b;
          r_dest <= bus.dest_sel;
          r_sf   <= bus.set_flags;
          r_c    <= bus.flags_in[FLAG_C];
          r_v    <= bus.flags_in[FLAG_V];
          r_prod <= bus.accumulate ? bus.acc_in : 32'd0;
          r_cnt  <= '0;
        end
        S_RUN: begin
          r_prod <= w_add;
          r_ma   <= r_ma << 1;
          r_mb   <= r_mb >> 1;
          r_cnt  <= r_cnt + 5'd1;
          // Outputs only change here, so they hold outside DONE.
          if (w_last) begin
            r_result <= w_add;
            r_rsel   <= r_dest;
            r_flags  <= w_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit.
// Covers MUL/MLA, flags, ignored starts, reset abort, PC write suppression.
module tb_mul_unit;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  int          g_lat;
  logic [31:0] g_res;
  logic [3:0]  g_sel;
  logic        g_we;
  logic        g_fwe;
  logic [3:0]  g_flags;

  mul_unit_if bus ();

  mul_unit u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Cycle (counted from the accepting edge) in which done is expected.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i + 1;
    return ((hi < 1) ? 1 : hi) + 1;
`else
    if (b === 32'hx) return 0;
    return 33;
`endif
  endfunction

  // Called in cycle 1 after an accepting edge. rp>0 re-pulses
  // start with op_a=9 in that cycle.
  task automatic wait_done(input int rp);
    g_lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.done) begin
        g_lat   = n;
        g_res   = bus.result;
        g_sel   = bus.result_sel;
        g_we    = bus.we;
        g_fwe   = bus.flags_we;
        g_flags = bus.flags_out;
        break;
      end
      if (n == rp) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd9;
      end
      tick();
      bus.start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [31:0] a, b, acc,
                        input logic mla, sf,
                        input logic [3:0] fl, dest,
                        input int rp);
    bus.op_a       = a;
    bus.op_b       = b;
    bus.acc_in     = acc;
    bus.accumulate = mla;
    bus.set_flags  = sf;
    bus.flags_in   = fl;
    bus.dest_sel   = dest;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    wait_done(rp);
  endtask

  int extra;

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.start = 0; bus.accumulate = 0; bus.set_flags = 0;
    bus.op_a = 0; bus.op_b = 0; bus.acc_in = 0;
    bus.dest_sel = 0; bus.flags_in = 0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_fwe", 32'(bus.flags_we), 0);
    chk("rst_res", bus.result, 0);
    chk("rst_sel", 32'(bus.result_sel), 0);
    chk("rst_flags", 32'(bus.flags_out), 0);
    reset = 1'b0;
    tick();

    // 6*7 MUL
    run_op(6, 7, 0, 0, 0, 4'h0, 4'd2, 0);
    chk("mul_lat", g_lat, exp_lat(7));
    chk("mul_res", g_res, 32'h2A);
    chk("mul_sel", 32'(g_sel), 2);
    chk("mul_we", 32'(g_we), 1);
    chk("mul_fwe", 32'(g_fwe), 0);
    tick();
    chk("post_done", 32'(bus.done), 0);
    chk("post_we", 32'(bus.we), 0);
    chk("post_busy", 32'(bus.busy), 0);
    chk("post_hold", bus.result, 32'h2A);
    chk("post_hold_sel", 32'(bus.result_sel), 2);

    // MLA wraps modulo 2^32
    run_op(32'hFFFF_FFFF, 2, 5, 1, 0, 4'h0, 4'd3, 0);
    chk("mla_lat", g_lat, exp_lat(2));
    chk("mla_res", g_res, 32'h3);
    chk("mla_we", 32'(g_we), 1);
    tick();

    // Zero result with flags, C/V carried through
    run_op(32'h1_0000, 32'h1_0000, 0, 0, 1, 4'b0011, 4'd1, 0);
    chk("flg_lat", g_lat, exp_lat(32'h1_0000));
    chk("flg_res", g_res, 0);
    chk("flg_out", 32'(g_flags), 32'b0111);
    chk("flg_we", 32'(g_fwe), 1);
    tick();

    // Negative result sets N
    run_op(32'hFFFF_FFFF, 3, 0, 0, 1, 4'b0000, 4'd5, 0);
    chk("neg_res", g_res, 32'hFFFF_FFFD);
    chk("neg_flags", 32'(g_flags), 32'b1000);
    tick();

    // Start re-pulsed while busy is ignored
    run_op(3, 4, 0, 0, 0, 4'h0, 4'd6, 5);
    chk("rp_lat", g_lat, exp_lat(4));
    chk("rp_res", g_res, 32'hC);
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.done) extra++;
    end
    chk("rp_single_done", extra, 0);

    // Start during DONE ignored; next cycle accepted
    run_op(6, 7, 0, 0, 0, 4'h0, 4'd2, 0);
    chk("dn_res0", g_res, 32'h2A);
    bus.op_a = 2; bus.op_b = 3; bus.dest_sel = 4'd4;
    bus.start = 1'b1;
    tick();
    chk("dn_idle", 32'(bus.busy), 0);
    tick();
    bus.start = 1'b0;
    chk("dn_accept", 32'(bus.busy), 1);
    wait_done(0);
    chk("dn_lat", g_lat, exp_lat(3));
    chk("dn_res", g_res, 32'h6);
    chk("dn_sel", 32'(g_sel), 4);
    tick();

    // Reset in RUN cycle 10
    bus.op_a = 5; bus.op_b = 32'hFFFF_FFFF; bus.dest_sel = 4'd7;
    bus.set_flags = 1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    chk("ab_busy_pre", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_done", 32'(bus.done), 0);
    chk("ab_res", bus.result, 0);
    chk("ab_sel", 32'(bus.result_sel), 0);
    chk("ab_flags", 32'(bus.flags_out), 0);
    tick();
    reset = 1'b0;
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.done || bus.we || bus.flags_we) extra++;
    end
    chk("ab_no_strobe", extra, 0);
    run_op(2, 2, 0, 0, 0, 4'h0, 4'd8, 0);
    chk("ab_lat", g_lat, exp_lat(2));
    chk("ab_res2", g_res, 32'h4);
    chk("ab_we2", 32'(g_we), 1);
    tick();

    // PC destination: done pulses, no write
    run_op(1, 3, 0, 0, 0, 4'h0, 4'hF, 0);
`ifdef MUL_EARLY_TERM_EN
    chk("pc_lat", g_lat, 3);
`else
    chk("pc_lat", g_lat, 33);
`endif
    chk("pc_res", g_res, 32'h3);
    chk("pc_we", 32'(g_we), 0);
    tick();

    // Multiplier zero
    run_op(32'h1234_5678, 0, 9, 1, 0, 4'h0, 4'd9, 0);
    chk("z_lat", g_lat, exp_lat(0));
    chk("z_res", g_res, 32'h9);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
